// File: rtl/ssc_pkg.sv
// rtl/ssc_pkg.sv - shared types and constants for the sort selection controller
package ssc_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        OUTER,
        MIN_LD,
        RD,
        CMP,
        SWAP1,
        SWAP2,
        DONE
    } ssc_state_e;

    function automatic int last_idx(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/ssc_min_unit.sv
// rtl/ssc_min_unit.sv - running minimum tracker with strict unsigned compare
module ssc_min_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              cmp_en,
    input  logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] load_idx,
    input  logic [ADDR_W-1:0] cmp_idx,
    output logic [DATA_W-1:0] min_val,
    output logic [ADDR_W-1:0] min_idx,
    output logic [DATA_W-1:0] orig_val
);

    // Strict less-than so that ties keep the earlier index.
    logic is_less;
    assign is_less = rdata < min_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_val  <= '0;
            min_idx  <= '0;
            orig_val <= '0;
        end else if (load) begin
            min_val  <= rdata;
            min_idx  <= load_idx;
            orig_val <= rdata;
        end else if (cmp_en && is_less) begin
            min_val  <= rdata;
            min_idx  <= cmp_idx;
        end
    end

endmodule

// File: rtl/ssc_controller.sv
// rtl/ssc_controller.sv - selection sort sequencing FSM over external counters and RAM
module ssc_controller
    import ssc_pkg::*;
#(
    parameter int N      = 256,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              clr_cnt1,
    output logic              en_cnt1,
    output logic              en_cnt2,
    output logic              pl_cnt2,
    input  logic [ADDR_W-1:0] cnt1_out,
    input  logic [ADDR_W-1:0] cnt2_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(last_idx(N));

    ssc_state_e state, state_next;

    logic              load;
    logic              cmp_en;
    logic [DATA_W-1:0] min_val;
    logic [ADDR_W-1:0] min_idx;
    logic [DATA_W-1:0] orig_val;

    ssc_min_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_min (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .cmp_en   (cmp_en),
        .rdata    (mem_rdata),
        .load_idx (cnt1_out),
        .cmp_idx  (cnt2_out),
        .min_val  (min_val),
        .min_idx  (min_idx),
        .orig_val (orig_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        clr_cnt1   = 1'b0;
        en_cnt1    = 1'b0;
        en_cnt2    = 1'b0;
        pl_cnt2    = 1'b0;
        mem_addr   = '0;
        mem_wr_en  = 1'b0;
        mem_wdata  = '0;
        load       = 1'b0;
        cmp_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_cnt1   = 1'b1;
                    state_next = OUTER;
                end
            end
            OUTER: begin
                if (cnt1_out == LAST) begin
                    state_next = DONE;
                end else begin
                    mem_addr   = cnt1_out;
                    pl_cnt2    = 1'b1;
                    state_next = MIN_LD;
                end
            end
            MIN_LD: begin
                load       = 1'b1;
                mem_addr   = cnt2_out;
                state_next = CMP;
            end
            CMP: begin
                cmp_en = 1'b1;
                if (cnt2_out == LAST) begin
                    state_next = SWAP1;
                end else begin
                    en_cnt2    = 1'b1;
                    state_next = RD;
                end
            end
            RD: begin
                mem_addr   = cnt2_out;
                state_next = CMP;
            end
            SWAP1: begin
                // Minimum already in place: skip both writes.
                if (min_idx == cnt1_out) begin
                    en_cnt1    = 1'b1;
                    state_next = OUTER;
                end else begin
                    mem_addr   = min_idx;
                    mem_wr_en  = 1'b1;
                    mem_wdata  = orig_val;
                    state_next = SWAP2;
                end
            end
            SWAP2: begin
                mem_addr   = cnt1_out;
                mem_wr_en  = 1'b1;
                mem_wdata  = min_val;
                en_cnt1    = 1'b1;
                state_next = OUTER;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ssc_controller.sv
// tb/tb_ssc_controller.sv - directed table-driven bench for ssc_controller
module tb_ssc_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_s [3];
    logic       busy    [3];
    logic       done    [3];
    logic       clr1    [3];
    logic       en1     [3];
    logic       en2     [3];
    logic       pl2     [3];
    logic [7:0] cnt1    [3];
    logic [7:0] cnt2    [3];
    logic [7:0] addr    [3];
    logic       wr_en   [3];
    logic [7:0] wdata   [3];
    logic [7:0] rdata   [3];
    logic [7:0] ram     [3][256];

    logic [7:0] pat [256];
    logic       ld_en  = 1'b0;
    int         ld_sel = 0;

    int nerr = 0;
    int nchk = 0;
    logic [15:0] wlog [$];

    ssc_controller #(.N(4), .DATA_W(8), .ADDR_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy[0]), .done(done[0]),
        .clr_cnt1(clr1[0]), .en_cnt1(en1[0]), .en_cnt2(en2[0]), .pl_cnt2(pl2[0]),
        .cnt1_out(cnt1[0]), .cnt2_out(cnt2[0]), .mem_addr(addr[0]),
        .mem_wr_en(wr_en[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]));

    ssc_controller #(.N(256), .DATA_W(8), .ADDR_W(8)) u_dut256 (
        .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy[1]), .done(done[1]),
        .clr_cnt1(clr1[1]), .en_cnt1(en1[1]), .en_cnt2(en2[1]), .pl_cnt2(pl2[1]),
        .cnt1_out(cnt1[1]), .cnt2_out(cnt2[1]), .mem_addr(addr[1]),
        .mem_wr_en(wr_en[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]));

    ssc_controller #(.N(1), .DATA_W(8), .ADDR_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[2]), .busy(busy[2]), .done(done[2]),
        .clr_cnt1(clr1[2]), .en_cnt1(en1[2]), .en_cnt2(en2[2]), .pl_cnt2(pl2[2]),
        .cnt1_out(cnt1[2]), .cnt2_out(cnt2[2]), .mem_addr(addr[2]),
        .mem_wr_en(wr_en[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]));

    // Datapath model: two counters and a synchronous-read RAM per instance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 3; g++) begin
                cnt1[g] <= '0;
                cnt2[g] <= '0;
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (clr1[g])      cnt1[g] <= '0;
                else if (en1[g])  cnt1[g] <= cnt1[g] + 8'd1;
                if (pl2[g])       cnt2[g] <= cnt1[g] + 8'd1;
                else if (en2[g])  cnt2[g] <= cnt2[g] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (ld_en && ld_sel == g) begin
                for (int k = 0; k < 256; k++) ram[g][k] <= pat[k];
            end else if (wr_en[g]) begin
                ram[g][addr[g]] <= wdata[g];
            end
            rdata[g] <= ram[g][addr[g]];
        end
    end

    typedef struct packed {
        logic [31:0] din;
        logic [31:0] dout;
        logic [7:0]  cyc;
        logic [7:0]  wr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_ram(input int sel);
        @(negedge clk);
        ld_sel = sel;
        ld_en  = 1'b1;
        @(negedge clk);
        ld_en  = 1'b0;
    endtask

    // Cycle 0 is the IDLE cycle that samples start; outputs sampled on negedges.
    task automatic run_sort(input int sel, input int budget, input int pulse_at,
                            output int done_cyc, output int n_done, output int n_wr,
                            output int n_pl, output int n_bad, output logic busy_after);
        done_cyc   = -1;
        n_done     = 0;
        n_wr       = 0;
        n_pl       = 0;
        n_bad      = 0;
        busy_after = 1'b1;
        wlog.delete();
        @(negedge clk);
        start_s[sel] = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start_s[sel] = (c == pulse_at);
            if (done[sel]) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (wr_en[sel]) begin
                n_wr++;
                wlog.push_back({addr[sel], wdata[sel]});
            end
            if (pl2[sel]) n_pl++;
            if (pl2[sel] && en2[sel]) n_bad++;
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy[sel];
            if (done_cyc >= 0 && c == done_cyc + 3) break;
        end
        start_s[sel] = 1'b0;
    endtask

    vec_t vecs [5];
    int   dcyc, ndone, nwr, npl, nbad, nram;
    logic bafter;
    logic [31:0] got;

    initial begin
        for (int g = 0; g < 3; g++) start_s[g] = 1'b0;
        for (int k = 0; k < 256; k++) pat[k] = 8'h00;

        vecs[0] = '{din: 32'h04030201, dout: 32'h04030201, cyc: 8'd20, wr: 8'd0};
        vecs[1] = '{din: 32'h01020304, dout: 32'h04030201, cyc: 8'd22, wr: 8'd4};
        vecs[2] = '{din: 32'h09020205, dout: 32'h09050202, cyc: 8'd22, wr: 8'd4};
        vecs[3] = '{din: 32'h07070707, dout: 32'h07070707, cyc: 8'd20, wr: 8'd0};
        vecs[4] = '{din: 32'h0180FF00, dout: 32'hFF800100, cyc: 8'd21, wr: 8'd2};

        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("reset_outputs",
                  32'({busy[g], done[g], clr1[g], en1[g], en2[g], pl2[g], addr[g], wr_en[g], wdata[g]}),
                  32'd0);
        end
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++) pat[k] = vecs[v].din[8*k +: 8];
            load_ram(0);
            run_sort(0, 60, -1, dcyc, ndone, nwr, npl, nbad, bafter);
            check($sformatf("v%0d_done_cycle", v), 32'(dcyc), 32'(vecs[v].cyc));
            check($sformatf("v%0d_writes", v), 32'(nwr), 32'(vecs[v].wr));
            check($sformatf("v%0d_done_pulses", v), 32'(ndone), 32'd1);
            check($sformatf("v%0d_busy_after", v), 32'(bafter), 32'd0);
            got = {ram[0][3], ram[0][2], ram[0][1], ram[0][0]};
            check($sformatf("v%0d_final_ram", v), got, vecs[v].dout);
            if (v == 1) begin
                check("rev_wlog_len", 32'(wlog.size()), 32'd4);
                if (wlog.size() == 4) begin
                    check("rev_w0", 32'(wlog[0]), 32'h0304);
                    check("rev_w1", 32'(wlog[1]), 32'h0001);
                    check("rev_w2", 32'(wlog[2]), 32'h0203);
                    check("rev_w3", 32'(wlog[3]), 32'h0102);
                end
            end
            if (v == 2 && wlog.size() >= 2) begin
                check("dup_w0", 32'(wlog[0]), 32'h0105);
                check("dup_w1", 32'(wlog[1]), 32'h0002);
            end
        end

        // Reset during the first SWAP1 that would write, then re-sort.
        pat[0] = 8'd4; pat[1] = 8'd3; pat[2] = 8'd2; pat[3] = 8'd1;
        load_ram(0);
        @(negedge clk);
        start_s[0] = 1'b1;
        begin
            int c;
            for (c = 0; c < 30; c++) begin
                @(negedge clk);
                start_s[0] = 1'b0;
                if (wr_en[0]) break;
            end
            check("swap1_reached", 32'(c < 30), 32'd1);
        end
        rst = 1'b1;
        #1;
        check("midsort_reset_outputs",
              32'({busy[0], done[0], clr1[0], en1[0], en2[0], pl2[0], addr[0], wr_en[0], wdata[0]}),
              32'd0);
        @(negedge clk);
        rst = 1'b0;
        got = {ram[0][3], ram[0][2], ram[0][1], ram[0][0]};
        check("midsort_ram_kept", got, 32'h01020304);
        run_sort(0, 60, 5, dcyc, ndone, nwr, npl, nbad, bafter);
        check("resort_done_cycle", 32'(dcyc), 32'd22);
        check("resort_done_pulses", 32'(ndone), 32'd1);
        got = {ram[0][3], ram[0][2], ram[0][1], ram[0][0]};
        check("resort_final_ram", got, 32'h04030201);

        // Full range, N=256, reverse order.
        for (int k = 0; k < 256; k++) pat[k] = 8'(255 - k);
        load_ram(1);
        run_sort(1, 70000, -1, dcyc, ndone, nwr, npl, nbad, bafter);
        check("n256_done_cycle", 32'(dcyc), 32'd65920);
        check("n256_done_pulses", 32'(ndone), 32'd1);
        check("n256_writes", 32'(nwr), 32'd256);
        check("n256_pl_loads", 32'(npl), 32'd255);
        check("n256_pl_en_overlap", 32'(nbad), 32'd0);
        check("n256_busy_after", 32'(bafter), 32'd0);
        nram = 0;
        for (int k = 0; k < 256; k++) if (ram[1][k] !== 8'(k)) nram++;
        check("n256_bad_ram_words", 32'(nram), 32'd0);

        // N=1: straight through OUTER to DONE.
        pat[0] = 8'h5A;
        load_ram(2);
        run_sort(2, 10, -1, dcyc, ndone, nwr, npl, nbad, bafter);
        check("n1_done_cycle", 32'(dcyc), 32'd2);
        check("n1_writes", 32'(nwr), 32'd0);
        check("n1_pl_loads", 32'(npl), 32'd0);
        check("n1_done_pulses", 32'(ndone), 32'd1);
        check("n1_ram", 32'(ram[2][0]), 32'h5A);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
